ls_ctrl: RTL and testbench
==========================

Name: ls_ctrl

Overview:
Load/store execution controller. Accepts one memory op at a time from the load/store buffer, computes the address, runs a single request/done transaction to the memory controller, and broadcasts the result on the load/store CDB. Loads to the I/O region are held until their ROB entry reaches the ROB head.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are I/O; loads there are non-speculative.

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low freezes all state and outputs
rdy_lsb_in  input  1  op valid from load/store buffer
opcode_lsb_in  input  `OP_WIDTH  op (`LB..`LHU, `SB..`SW)
vj_lsb_in  input  `DATA_WIDTH  base register value
vk_lsb_in  input  `DATA_WIDTH  store data
imm_lsb_in  input  `DATA_WIDTH  offset
rob_id_lsb_in  input  `ROB_WIDTH  ROB tag
idle_lsb_out  output  1  ready to accept an op
head_id_rob_in  input  `ROB_WIDTH  current ROB head tag
refresh_rob_cdb_in  input  1  pipeline flush
req_mc_out  output  1  memory request, held until done
rw_mc_out  output  1  1 = write, 0 = read
addr_mc_out  output  `DATA_WIDTH  byte address
data_mc_out  output  `DATA_WIDTH  store data, LSB-aligned
len_mc_out  output  3  access bytes: 1, 2 or 4
done_mc_in  input  1  one-cycle completion pulse
data_mc_in  input  `DATA_WIDTH  raw read data, LSB-aligned, valid with done
rdy_cdb_out  output  1  one-cycle broadcast pulse
result_cdb_out  output  `DATA_WIDTH  load result; 0 for stores
rob_id_cdb_out  output  `ROB_WIDTH  tag of the completed op

Behaviour:
- States: IDLE, WAIT_HEAD, WAIT_MEM, DRAIN.
- idle_lsb_out = (state == IDLE), combinational.
- Reset (and refresh, see below): state IDLE; req_mc_out=0, rdy_cdb_out=0, rw_mc_out=0, len_mc_out=0; addr/data/result/rob_id outputs = 0.
- rdy_in low: no state change, all outputs hold. Reset still wins over rdy_in.
- rdy_cdb_out defaults to 0 every enabled cycle (one-cycle pulse).
- Accept: IDLE and rdy_lsb_in at the edge. Latch the op.
  - addr = vj + imm, mod 2^32.
  - len: B/BU/SB = 1, H/HU/SH = 2, W/SW = 4.
  - rw = 1 for stores.
  - data_mc_out = vk masked to len bytes.
- Next state after accept:
  - Load with addr >= IO_BASE and rob_id != head_id_rob_in: WAIT_HEAD.
  - Otherwise: WAIT_MEM, with req_mc_out=1 from the next cycle.
- rdy_lsb_in outside IDLE is ignored (protocol error, never occurs).
- WAIT_HEAD: when the latched rob_id == head_id_rob_in, go to WAIT_MEM and assert req_mc_out the next cycle.
- WAIT_MEM: req_mc_out and all mc outputs stay stable until done_mc_in. On done:
  - req_mc_out=0, state IDLE.
  - rdy_cdb_out=1 for one cycle with rob_id_cdb_out = latched tag.
  - Result: LB/LH sign-extend the low 8/16 bits; LBU/LHU zero-extend; LW passes through; stores give 0.
  - idle_lsb_out is high in the same cycle as the CDB pulse.
- Latency: accept at edge t; req high in cycle t+1; done sampled at edge t+k; CDB pulse in cycle t+k+1.
- refresh_rob_cdb_in (priority over all except reset/rdy_in):
  - IDLE / WAIT_HEAD: go to IDLE; no memory access.
  - WAIT_MEM with a load: go to DRAIN. Keep req_mc_out high until done; then drop req and go to IDLE with no CDB pulse.
  - WAIT_MEM with a store: the store is committed and must complete. Continue normally, but suppress the CDB pulse.
  - Same-cycle done and refresh: the transaction ends, no CDB pulse, state IDLE.
  - An op offered in the same cycle as refresh is dropped.
- DRAIN: idle_lsb_out=0. done_mc_in → IDLE.

Optional Feature:
LSC_MISALIGN_TRAP_EN
- Defined: a halfword at an odd address, or a word with addr[1:0] != 0, issues no memory request. The CDB pulse fires one cycle after accept with result 0 and state returns to IDLE; misaligned stores are discarded.
- Undefined: no alignment check; the address passes to memory unchanged.

Test Plan:
- LW: vj=0x100, imm=4, mc returns 0xDEADBEEF after 3 cycles → addr 0x104, len 4, rw 0; CDB result 0xDEADBEEF with correct tag one cycle after done; idle high the same cycle.
- LB: data 0x00000080 → result 0xFFFFFF80. LHU: data 0x0001F00D → result 0x0000F00D.
- SH: vj=0x200, imm=-2, vk=0x12345678 → addr 0x1FE, len 2, rw 1, data 0x5678; CDB result 0 after done.
- Load to 0x30004, rob_id=5, head=3 → no req while head≠5; head=5 → req next cycle, normal completion.
- Refresh during load WAIT_MEM → req stays high until done, no CDB pulse, then idle. Refresh during store → store completes, no CDB pulse.
- rdy_in low for 4 cycles mid-WAIT_MEM → outputs frozen, done ignored; resumes correctly when rdy_in returns high.

Source files
------------

// File: rtl/ls_ctrl_if.sv
// Load/store controller bus bundle: LSB op intake, memory-controller
// transaction and CDB broadcast. Also supplies the op-code/width macros.
`ifndef LS_CTRL_IF_SV
`define LS_CTRL_IF_SV

`ifndef OP_WIDTH
`define OP_WIDTH   4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH  4
`endif
`ifndef LB
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB  4'd5
`define SH  4'd6
`define SW  4'd7
`endif

interface ls_ctrl_if;
  logic                   rdy_lsb_in;
  logic [`OP_WIDTH-1:0]   opcode_lsb_in;
  logic [`DATA_WIDTH-1:0] vj_lsb_in;
  logic [`DATA_WIDTH-1:0] vk_lsb_in;
  logic [`DATA_WIDTH-1:0] imm_lsb_in;
  logic [`ROB_WIDTH-1:0]  rob_id_lsb_in;
  logic                   idle_lsb_out;
  logic                   req_mc_out;
  logic                   rw_mc_out;
  logic [`DATA_WIDTH-1:0] addr_mc_out;
  logic [`DATA_WIDTH-1:0] data_mc_out;
  logic [2:0]             len_mc_out;
  logic                   done_mc_in;
  logic [`DATA_WIDTH-1:0] data_mc_in;
  logic                   rdy_cdb_out;
  logic [`DATA_WIDTH-1:0] result_cdb_out;
  logic [`ROB_WIDTH-1:0]  rob_id_cdb_out;

  // master: the controller; slave: LSB, memory controller and CDB side
  modport master (
    input  rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in, imm_lsb_in,
           rob_id_lsb_in, done_mc_in, data_mc_in,
    output idle_lsb_out, req_mc_out, rw_mc_out, addr_mc_out, data_mc_out,
           len_mc_out, rdy_cdb_out, result_cdb_out, rob_id_cdb_out
  );
  modport slave (
    output rdy_lsb_in, opcode_lsb_in, vj_lsb_in, vk_lsb_in, imm_lsb_in,
           rob_id_lsb_in, done_mc_in, data_mc_in,
    input  idle_lsb_out, req_mc_out, rw_mc_out, addr_mc_out, data_mc_out,
           len_mc_out, rdy_cdb_out, result_cdb_out, rob_id_cdb_out
  );
endinterface

`endif

// File: rtl/ls_ctrl.sv
// Load/store execution controller: one op at a time, one memory transaction,
// CDB broadcast. Optional LSC_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module ls_ctrl #(
  parameter logic [`DATA_WIDTH-1:0] IO_BASE = 32'h00030000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [`ROB_WIDTH-1:0] head_id_rob_in,
  input  logic                  refresh_rob_cdb_in,
  ls_ctrl_if.master             bus
);
  typedef enum logic [1:0] {IDLE, WAIT_HEAD, WAIT_MEM, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   rw_q, rw_d;
  logic [`DATA_WIDTH-1:0] addr_q, addr_d;
  logic [`DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]             len_q, len_d;
  logic [`OP_WIDTH-1:0]   op_q, op_d;
  logic [`ROB_WIDTH-1:0]  rob_q, rob_d;
  logic                   cdb_q, cdb_d;
  logic [`DATA_WIDTH-1:0] result_q, result_d;
  logic [`ROB_WIDTH-1:0]  cdb_rob_q, cdb_rob_d;

  logic [`DATA_WIDTH-1:0] acc_addr;
  logic [2:0]             acc_len;
  logic                   acc_store;
  logic                   misalign;
  logic [`DATA_WIDTH-1:0] load_val;

  assign acc_addr  = bus.vj_lsb_in + bus.imm_lsb_in;
  assign acc_store = (bus.opcode_lsb_in == `SB) || (bus.opcode_lsb_in == `SH) ||
                     (bus.opcode_lsb_in == `SW);

  always_comb begin
    acc_len = 3'd4;
    case (bus.opcode_lsb_in)
      `LB, `LBU, `SB: acc_len = 3'd1;
      `LH, `LHU, `SH: acc_len = 3'd2;
      default:        acc_len = 3'd4;
    endcase
  end

`ifdef LSC_MISALIGN_TRAP_EN
  assign misalign = ((acc_len == 3'd2) && acc_addr[0]) ||
                    ((acc_len == 3'd4) && (acc_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Extend raw memory data according to the latched load flavour
  always_comb begin
    load_val = '0;
    case (op_q)
      `LB:     load_val = {{24{bus.data_mc_in[7]}}, bus.data_mc_in[7:0]};
      `LH:     load_val = {{16{bus.data_mc_in[15]}}, bus.data_mc_in[15:0]};
      `LW:     load_val = bus.data_mc_in;
      `LBU:    load_val = {24'd0, bus.data_mc_in[7:0]};
      `LHU:    load_val = {16'd0, bus.data_mc_in[15:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    len_d     = len_q;
    op_d      = op_q;
    rob_d     = rob_q;
    cdb_d     = 1'b0;
    result_d  = result_q;
    cdb_rob_d = cdb_rob_q;
    case (state_q)
      IDLE, WAIT_HEAD: begin
        if (refresh_rob_cdb_in) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          rw_d      = 1'b0;
          addr_d    = '0;
          data_d    = '0;
          len_d     = '0;
          result_d  = '0;
          cdb_rob_d = '0;
        end else if (state_q == WAIT_HEAD) begin
          if (rob_q == head_id_rob_in) begin
            state_d = WAIT_MEM;
            req_d   = 1'b1;
          end
        end else if (bus.rdy_lsb_in) begin
          op_d   = bus.opcode_lsb_in;
          rob_d  = bus.rob_id_lsb_in;
          addr_d = acc_addr;
          len_d  = acc_len;
          rw_d   = acc_store;
          data_d = (acc_len == 3'd1) ? (bus.vk_lsb_in & 32'h000000FF) :
                   (acc_len == 3'd2) ? (bus.vk_lsb_in & 32'h0000FFFF) : bus.vk_lsb_in;
          if (misalign) begin
            cdb_d     = 1'b1;
            result_d  = '0;
            cdb_rob_d = bus.rob_id_lsb_in;
          end else if (!acc_store && (acc_addr >= IO_BASE) &&
                       (bus.rob_id_lsb_in != head_id_rob_in)) begin
            state_d = WAIT_HEAD;
          end else begin
            state_d = WAIT_MEM;
            req_d   = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.done_mc_in) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!refresh_rob_cdb_in) begin
            cdb_d     = 1'b1;
            result_d  = rw_q ? '0 : load_val;
            cdb_rob_d = rob_q;
          end
        end else if (refresh_rob_cdb_in) begin
          // Flushed loads and committed stores both finish silently
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.done_mc_in) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      op_q      <= '0;
      rob_q     <= '0;
      cdb_q     <= 1'b0;
      result_q  <= '0;
      cdb_rob_q <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      len_q     <= len_d;
      op_q      <= op_d;
      rob_q     <= rob_d;
      cdb_q     <= cdb_d;
      result_q  <= result_d;
      cdb_rob_q <= cdb_rob_d;
    end
  end

  assign bus.idle_lsb_out   = (state_q == IDLE);
  assign bus.req_mc_out     = req_q;
  assign bus.rw_mc_out      = rw_q;
  assign bus.addr_mc_out    = addr_q;
  assign bus.data_mc_out    = data_q;
  assign bus.len_mc_out     = len_q;
  assign bus.rdy_cdb_out    = cdb_q;
  assign bus.result_cdb_out = result_q;
  assign bus.rob_id_cdb_out = cdb_rob_q;
endmodule

// File: tb/tb_ls_ctrl.sv
// Bench for ls_ctrl: directed cases with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_ls_ctrl;
  localparam logic [3:0] OP_LB = 4'd0, OP_LH = 4'd1, OP_LW = 4'd2, OP_LBU = 4'd3,
                         OP_LHU = 4'd4, OP_SB = 4'd5, OP_SH = 4'd6, OP_SW = 4'd7;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, refresh = 1'b0;
  logic [3:0] head = 4'd0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ls_ctrl_if intf();
  ls_ctrl dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .head_id_rob_in(head),
               .refresh_rob_cdb_in(refresh), .bus(intf.master));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [3:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op >= OP_SB;
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] b, h;
    b = d % 256;
    h = d % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b - 256 : b;
      OP_LH:   return (h >= 32768) ? h - 65536 : h;
      OP_LBU:  return b;
      OP_LHU:  return h;
      OP_LW:   return d;
      default: return 0;
    endcase
  endfunction

  // Memory responder: done after rsp_delay further cycles of req
  int rsp_delay = 0, rsp_cnt = 0;
  bit rsp_rand = 0;
  logic [31:0] rsp_data = 0;
  always @(posedge clk) begin
    #2;
    intf.done_mc_in = 1'b0;
    if (rst || !intf.req_mc_out) rsp_cnt = 0;
    else if (rsp_cnt >= rsp_delay) begin
      intf.done_mc_in = 1'b1;
      intf.data_mc_in = rsp_data;
      rsp_cnt = 0;
      if (rsp_rand) begin
        rsp_delay = $urandom_range(0, 4);
        rsp_data  = $urandom;
      end
    end else rsp_cnt++;
  end

  // Transaction-level model: op held / waiting for head / flushed
  bit m_busy = 0, m_hold = 0, m_flush = 0, m_rw = 0, e_cdb = 0;
  logic [3:0]  m_op = 0, m_rob = 0, e_rob = 0;
  logic [31:0] m_addr = 0, m_data = 0, e_res = 0, t_addr;
  int m_len = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_hold = 0; m_flush = 0; e_cdb = 0;
    end else if (rdy) begin
      e_cdb = 0;
      if (!m_busy) begin
        if (!refresh && intf.rdy_lsb_in) begin
          t_addr = intf.vj_lsb_in + intf.imm_lsb_in;
`ifdef LSC_MISALIGN_TRAP_EN
          if (t_addr % len_of(intf.opcode_lsb_in) != 0) begin
            e_cdb = 1; e_res = 0; e_rob = intf.rob_id_lsb_in;
          end else
`endif
          begin
            m_busy = 1; m_flush = 0;
            m_op = intf.opcode_lsb_in; m_rob = intf.rob_id_lsb_in;
            m_addr = t_addr; m_len = len_of(m_op); m_rw = is_store(m_op);
            m_data = (m_len == 4) ? intf.vk_lsb_in : intf.vk_lsb_in % (1 << (8 * m_len));
            m_hold = !m_rw && t_addr >= 32'h00030000 && m_rob != head;
          end
        end
      end else if (m_hold) begin
        if (refresh) m_busy = 0;
        else if (m_rob == head) m_hold = 0;
      end else if (intf.done_mc_in) begin
        m_busy = 0;
        if (!m_flush && !refresh) begin
          e_cdb = 1; e_rob = m_rob;
          e_res = m_rw ? 0 : load_val(m_op, intf.data_mc_in);
        end
      end else if (refresh) m_flush = 1;
    end
  end

  // Compare + monitor for directed literal checks
  int mon_req_cycles = 0, cdb_cnt = 0;
  logic [31:0] mon_addr = 0, mon_data = 0, mon_res = 0;
  logic [2:0] mon_len = 0;
  logic mon_rw = 0, mon_idle_cdb = 0;
  logic [3:0] mon_rob = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("idle", 32'(intf.idle_lsb_out), 32'(!m_busy));
      chk("req", 32'(intf.req_mc_out), 32'(m_busy && !m_hold));
      chk("cdb_pulse", 32'(intf.rdy_cdb_out), 32'(e_cdb));
      if (m_busy && !m_hold) begin
        chk("addr", intf.addr_mc_out, m_addr);
        chk("len", 32'(intf.len_mc_out), m_len);
        chk("rw", 32'(intf.rw_mc_out), 32'(m_rw));
        chk("wdata", intf.data_mc_out, m_data);
      end
      if (e_cdb) begin
        chk("result", intf.result_cdb_out, e_res);
        chk("cdb_rob", 32'(intf.rob_id_cdb_out), 32'(e_rob));
      end
      if (intf.req_mc_out) begin
        mon_req_cycles++;
        mon_addr = intf.addr_mc_out; mon_len = intf.len_mc_out;
        mon_rw = intf.rw_mc_out; mon_data = intf.data_mc_out;
      end
      if (intf.rdy_cdb_out) begin
        cdb_cnt++;
        mon_res = intf.result_cdb_out; mon_rob = intf.rob_id_cdb_out;
        mon_idle_cdb = intf.idle_lsb_out;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [3:0] rob);
    intf.rdy_lsb_in = 1; intf.opcode_lsb_in = op; intf.vj_lsb_in = vj;
    intf.vk_lsb_in = vk; intf.imm_lsb_in = imm; intf.rob_id_lsb_in = rob;
    mon_req_cycles = 0;
    tick();
    intf.rdy_lsb_in = 0;
  endtask

  task automatic wait_done(input int max);
    int i = 0;
    while (!intf.idle_lsb_out && i < max) begin tick(); i++; end
    if (i >= max) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout actual=busy expected=idle");
    end
    tick();
  endtask

  int c0;
  initial begin
    intf.rdy_lsb_in = 0; intf.opcode_lsb_in = 0; intf.vj_lsb_in = 0; intf.vk_lsb_in = 0;
    intf.imm_lsb_in = 0; intf.rob_id_lsb_in = 0; intf.done_mc_in = 0; intf.data_mc_in = 0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_addr", intf.addr_mc_out, 0);
    chk("rst_len", 32'(intf.len_mc_out), 0);
    chk("rst_result", intf.result_cdb_out, 0);
    chk("rst_rob", 32'(intf.rob_id_cdb_out), 0);
    tick();

    // LW through the full transaction
    rsp_delay = 2; rsp_data = 32'hDEADBEEF;
    issue(OP_LW, 32'h100, 0, 4, 4'd7);
    wait_done(20);
    chk("lw_addr", mon_addr, 32'h104);
    chk("lw_len", 32'(mon_len), 4);
    chk("lw_rw", 32'(mon_rw), 0);
    chk("lw_req_cycles", mon_req_cycles, 3);
    chk("lw_res", mon_res, 32'hDEADBEEF);
    chk("lw_rob", 32'(mon_rob), 7);
    chk("lw_idle_at_cdb", 32'(mon_idle_cdb), 1);

    rsp_delay = 0; rsp_data = 32'h00000080;
    issue(OP_LB, 32'h40, 0, 1, 4'd1);
    wait_done(20);
    chk("lb_res", mon_res, 32'hFFFFFF80);
    rsp_data = 32'h0001F00D;
    issue(OP_LHU, 32'h40, 0, 2, 4'd2);
    wait_done(20);
    chk("lhu_res", mon_res, 32'h0000F00D);

    rsp_delay = 1;
    issue(OP_SH, 32'h200, 32'h12345678, 32'hFFFFFFFE, 4'd3);
    wait_done(20);
    chk("sh_addr", mon_addr, 32'h1FE);
    chk("sh_len", 32'(mon_len), 2);
    chk("sh_rw", 32'(mon_rw), 1);
    chk("sh_data", mon_data, 32'h5678);
    chk("sh_res", mon_res, 0);

    // I/O load held until its ROB entry is at the head
    head = 4'd3; rsp_data = 32'h11223344;
    issue(OP_LW, 32'h30000, 0, 4, 4'd5);
    repeat (6) tick();
    chk("io_no_req", mon_req_cycles, 0);
    head = 4'd5;
    wait_done(20);
    chk("io_res", mon_res, 32'h11223344);
    chk("io_rob", 32'(mon_rob), 5);

    // Flush during load and during store: no broadcast
    c0 = cdb_cnt; rsp_delay = 4;
    issue(OP_LW, 32'h100, 0, 0, 4'd1);
    refresh = 1; tick(); refresh = 0;
    wait_done(20);
    chk("flush_ld_nocdb", cdb_cnt, c0);
    chk("flush_ld_req", mon_req_cycles, 5);
    issue(OP_SW, 32'h100, 32'hA5A5A5A5, 0, 4'd2);
    refresh = 1; tick(); refresh = 0;
    wait_done(20);
    chk("flush_st_nocdb", cdb_cnt, c0);
    chk("flush_st_req", mon_req_cycles, 5);

    // Freeze mid-transaction
    rsp_delay = 2; rsp_data = 32'hCAFEF00D;
    issue(OP_LW, 32'h80, 0, 0, 4'd6);
    rdy = 0; repeat (4) tick(); rdy = 1;
    wait_done(20);
    chk("freeze_cdb", cdb_cnt, c0 + 1);
    chk("freeze_res", mon_res, 32'hCAFEF00D);

    // Random traffic
    rsp_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      rdy = ($urandom % 8) != 0;
      refresh = ($urandom % 25) == 0;
      head = 4'($urandom % 8);
      intf.rdy_lsb_in = $urandom % 2;
      intf.opcode_lsb_in = 4'($urandom % 8);
      intf.vj_lsb_in = ($urandom % 4 != 0) ? $urandom % 256 : 32'h2FFF0 + $urandom % 64;
      intf.imm_lsb_in = 32'($urandom % 32) - 16;
      intf.vk_lsb_in = $urandom;
      intf.rob_id_lsb_in = 4'($urandom % 8);
      tick();
    end
    rdy = 1; intf.rdy_lsb_in = 0; refresh = 1; tick(); refresh = 0;
    wait_done(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
